// File: rtl/axi4l_mem_pkg.sv
// Shared encodings, FSM state types and default address map for the AXI4-Lite memory slave.
package axi4l_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEF_MEM_BYTES = 2097152;
    localparam logic [31:0] DEF_RO_BASE   = 32'h3000_0000;
    localparam int unsigned DEF_RO_BYTES  = 1048576;
    localparam logic [31:0] DEF_CON_ADDR  = 32'h1000_0000;

    typedef enum logic [1:0] {W_IDLE, W_CON, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_e;
    typedef enum logic [1:0] {RG_RAM, RG_RO, RG_CON, RG_NONE} region_e;

endpackage

// File: rtl/axi4l_mem_decode.sv
// Combinational address decoder: region classification and word index within that region.
module axi4l_mem_decode
    import axi4l_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
    parameter logic [31:0] RO_BASE   = DEF_RO_BASE,
    parameter int unsigned RO_BYTES  = DEF_RO_BYTES,
    parameter logic [31:0] CON_ADDR  = DEF_CON_ADDR,
    parameter int unsigned IDX_W     = 20
) (
    input  logic [31:0]      addr_i,
    output region_e          region_o,
    output logic [IDX_W-1:0] idx_o
);

    localparam int unsigned SHIFT  = $clog2(DATA_W / 8);
    // 33-bit end bound so a region touching the top of the map does not wrap.
    localparam logic [32:0] RO_END = {1'b0, RO_BASE} + 33'(RO_BYTES);

    always_comb begin
        region_o = RG_NONE;
        idx_o    = '0;
        if ({1'b0, addr_i} < 33'(MEM_BYTES)) begin
            region_o = RG_RAM;
            idx_o    = IDX_W'(addr_i >> SHIFT);
        end else if (RO_BYTES != 0 && addr_i >= RO_BASE && {1'b0, addr_i} < RO_END) begin
            region_o = RG_RO;
            idx_o    = IDX_W'((addr_i - RO_BASE) >> SHIFT);
        end else if (addr_i == CON_ADDR) begin
            region_o = RG_CON;
        end
    end

endmodule

// File: rtl/axi4l_mem_slave.sv
// AXI4-Lite slave with RAM, read-only region and console byte port; independent read and write FSMs.
module axi4l_mem_slave
    import axi4l_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES,
    parameter logic [31:0] RO_BASE   = DEF_RO_BASE,
    parameter int unsigned RO_BYTES  = DEF_RO_BYTES,
    parameter logic [31:0] CON_ADDR  = DEF_CON_ADDR,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [31:0]       araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              con_valid,
    input  logic              con_ready,
    output logic [7:0]        con_data
);

    localparam int unsigned BPW       = DATA_W / 8;
    localparam int unsigned RAM_WORDS = MEM_BYTES / BPW;
    localparam int unsigned RO_WORDS  = (RO_BYTES == 0) ? 1 : RO_BYTES / BPW;
    localparam int unsigned RAM_IW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned RO_IW     = (RO_WORDS > 1) ? $clog2(RO_WORDS) : 1;
    localparam int unsigned IDX_W     = (RAM_IW > RO_IW) ? RAM_IW : RO_IW;

    logic [DATA_W-1:0] ram_mem [RAM_WORDS];
    logic [DATA_W-1:0] ro_mem  [RO_WORDS];

    // Readies are held off until the first clock edge that samples resetn high.
    logic live_q;

    wr_state_e         wr_state_q, wr_state_d;
    logic              aw_have_q, aw_have_d, w_have_q, w_have_d;
    logic [31:0]       awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BPW-1:0]    wstrb_q;
    logic [1:0]        bresp_q, bresp_d;
    logic              ram_we, aw_hs, w_hs;
    region_e           wr_region;
    logic [IDX_W-1:0]  wr_idx;

    rd_state_e         rd_state_q, rd_state_d;
    logic [3:0]        rd_cnt_q, rd_cnt_d;
    logic [31:0]       araddr_q, rd_addr;
    logic [DATA_W-1:0] rdata_q, rd_word;
    logic [1:0]        rresp_q, rd_resp;
    logic              rd_load, ar_hs;
    region_e           rd_region;
    logic [IDX_W-1:0]  rd_idx;

    axi4l_mem_decode #(.DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .RO_BASE(RO_BASE),
                       .RO_BYTES(RO_BYTES), .CON_ADDR(CON_ADDR), .IDX_W(IDX_W))
        u_wr_dec (.addr_i(awaddr_q), .region_o(wr_region), .idx_o(wr_idx));

    axi4l_mem_decode #(.DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .RO_BASE(RO_BASE),
                       .RO_BYTES(RO_BYTES), .CON_ADDR(CON_ADDR), .IDX_W(IDX_W))
        u_rd_dec (.addr_i(rd_addr), .region_o(rd_region), .idx_o(rd_idx));

    assign awready   = live_q && (wr_state_q == W_IDLE) && !aw_have_q;
    assign wready    = live_q && (wr_state_q == W_IDLE) && !w_have_q;
    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign bvalid    = (wr_state_q == W_RESP);
    assign bresp     = bresp_q;
    assign con_valid = (wr_state_q == W_CON);
    assign con_data  = wdata_q[7:0];

    always_comb begin
        wr_state_d = wr_state_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        bresp_d    = bresp_q;
        ram_we     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) aw_have_d = 1'b1;
                if (w_hs)  w_have_d  = 1'b1;
                if (aw_have_q && w_have_q) begin
                    case (wr_region)
                        RG_RAM:  begin ram_we = 1'b1; bresp_d = RESP_OKAY; wr_state_d = W_RESP; end
                        RG_RO:   begin bresp_d = RESP_SLVERR; wr_state_d = W_RESP; end
                        RG_CON:  wr_state_d = W_CON;
                        default: begin bresp_d = RESP_DECERR; wr_state_d = W_RESP; end
                    endcase
                end
            end
            W_CON: if (con_ready) begin
                bresp_d    = RESP_OKAY;
                wr_state_d = W_RESP;
            end
            W_RESP: if (bready) begin
                wr_state_d = W_IDLE;
                aw_have_d  = 1'b0;
                w_have_d   = 1'b0;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            live_q     <= 1'b0;
            wr_state_q <= W_IDLE;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
        end else begin
            live_q     <= 1'b1;
            wr_state_q <= wr_state_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            bresp_q    <= bresp_d;
            if (aw_hs) awaddr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && ram_we) begin
            for (int unsigned b = 0; b < BPW; b++) begin
                if (wstrb_q[b]) ram_mem[RAM_IW'(wr_idx)][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign arready = live_q && (rd_state_q == R_IDLE);
    assign ar_hs   = arvalid && arready;
    assign rvalid  = (rd_state_q == R_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    // With RD_LAT=1 the array is sampled on the AR edge, so decode the live address.
    assign rd_addr = (rd_state_q == R_IDLE) ? araddr : araddr_q;

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_region)
            RG_RAM:  rd_word = ram_mem[RAM_IW'(rd_idx)];
            RG_RO:   rd_word = ro_mem[RO_IW'(rd_idx)];
            RG_CON:  rd_word = '0;
            default: rd_resp = RESP_DECERR;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_load    = 1'b0;
        case (rd_state_q)
            R_IDLE: if (ar_hs) begin
                if (RD_LAT == 1) begin
                    rd_load    = 1'b1;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d   = 4'(RD_LAT - 1);
                    rd_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == 4'd1) begin
                    rd_load    = 1'b1;
                    rd_cnt_d   = '0;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - 4'd1;
                end
            end
            R_RESP: if (rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            araddr_q   <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            if (ar_hs) araddr_q <= araddr;
            if (rd_load) begin
                rdata_q <= rd_word;
                rresp_q <= rd_resp;
            end
        end
    end

endmodule
